// File: rtl/vga_pattern_gen_if.sv
// Pixel-side signal bundle between the sync generators/colour mux and the pattern generator.
interface vga_pattern_gen_if;
  logic       h_display;
  logic       v_display;
  logic [1:0] mode;
  logic [1:0] R_out;
  logic [1:0] G_out;
  logic [1:0] B_out;
  logic [9:0] x_pos;
  logic [8:0] y_pos;

  modport master (
    output h_display, v_display, mode,
    input  R_out, G_out, B_out, x_pos, y_pos
  );

  modport slave (
    input  h_display, v_display, mode,
    output R_out, G_out, B_out, x_pos, y_pos
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: bars, checkerboard, bouncing box or grey, one cycle after each active pixel.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX      = 32,
  parameter int BAR_W    = 80
) (
  input logic              clk,
  input logic              reset,
  vga_pattern_gen_if.slave vga
);
  localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - 1);
  localparam logic [8:0]  Y_MAX   = 9'(V_ACTIVE - 1);
  localparam logic [9:0]  BX_MAX  = 10'(H_ACTIVE - BOX);
  localparam logic [8:0]  BY_MAX  = 9'(V_ACTIVE - BOX);
  localparam logic [6:0]  BAR_MAX = 7'(BAR_W - 1);
  localparam logic [10:0] BOX_W   = 11'(BOX);

  logic       h_d_q, h_d_d, v_d_q, v_d_d;
  logic [9:0] x_cnt_q, x_cnt_d;
  logic [6:0] bar_sub_q, bar_sub_d;
  logic [2:0] bar_idx_q, bar_idx_d;
  logic [8:0] y_cnt_q, y_cnt_d;
  logic [1:0] active_mode_q, active_mode_d;
  logic [9:0] bx_q, bx_d;
  logic [8:0] by_q, by_d;
  logic       dx_q, dx_d, dy_q, dy_d;
  logic [1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [9:0] x_pos_q, x_pos_d;
  logic [8:0] y_pos_q, y_pos_d;

  logic       act, h_fall, frame_end, in_box;
  logic [2:0] bar_c;

  always_comb begin
    act       = vga.h_display & vga.v_display;
    h_fall    = h_d_q & ~vga.h_display;
    frame_end = v_d_q & ~vga.v_display;
    h_d_d     = vga.h_display;
    v_d_d     = vga.v_display;

    x_cnt_d       = x_cnt_q;
    bar_sub_d     = bar_sub_q;
    bar_idx_d     = bar_idx_q;
    y_cnt_d       = y_cnt_q;
    active_mode_d = active_mode_q;
    bx_d          = bx_q;
    by_d          = by_q;
    dx_d          = dx_q;
    dy_d          = dy_q;

    // x_cnt/bar_* describe the pixel being sampled this cycle, not the one on the outputs
    if (act) begin
      if (x_cnt_q != X_MAX) x_cnt_d = x_cnt_q + 10'd1;
      if (bar_sub_q == BAR_MAX) begin
        bar_sub_d = 7'd0;
        if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_sub_d = bar_sub_q + 7'd1;
      end
    end else begin
      x_cnt_d   = 10'd0;
      bar_sub_d = 7'd0;
      bar_idx_d = 3'd0;
    end

    if (!vga.v_display)                  y_cnt_d = 9'd0;
    else if (h_fall && y_cnt_q != Y_MAX) y_cnt_d = y_cnt_q + 9'd1;

    if (frame_end) begin
      active_mode_d = vga.mode;
      if (active_mode_q == 2'd2) begin
        if (dx_q) begin
          if (bx_q == BX_MAX) begin dx_d = 1'b0; bx_d = bx_q - 10'd1; end
          else                                   bx_d = bx_q + 10'd1;
        end else begin
          if (bx_q == 10'd0)  begin dx_d = 1'b1; bx_d = 10'd1; end
          else                                   bx_d = bx_q - 10'd1;
        end
        if (dy_q) begin
          if (by_q == BY_MAX) begin dy_d = 1'b0; by_d = by_q - 9'd1; end
          else                                   by_d = by_q + 9'd1;
        end else begin
          if (by_q == 9'd0)   begin dy_d = 1'b1; by_d = 9'd1; end
          else                                   by_d = by_q - 9'd1;
        end
      end
    end

    bar_c  = 3'd7 - bar_idx_q;
    in_box = ({1'b0, x_cnt_q} >= {1'b0, bx_q}) && ({1'b0, x_cnt_q} < ({1'b0, bx_q} + BOX_W)) &&
             ({2'b00, y_cnt_q} >= {2'b00, by_q}) && ({2'b00, y_cnt_q} < ({2'b00, by_q} + BOX_W));

    r_d     = 2'b00;
    g_d     = 2'b00;
    b_d     = 2'b00;
    x_pos_d = act ? x_cnt_q : 10'd0;
    y_pos_d = y_cnt_q;
    if (act) begin
      case (active_mode_q)
        2'd0: begin
          r_d = {2{bar_c[2]}};
          g_d = {2{bar_c[1]}};
          b_d = {2{bar_c[0]}};
        end
        2'd1: begin
          if (x_cnt_q[5] ^ y_cnt_q[5]) begin r_d = 2'b11; g_d = 2'b11; b_d = 2'b11; end
        end
        2'd2: begin
          if (in_box) r_d = 2'b11;
          else        b_d = 2'b01;
        end
        default: begin r_d = 2'b10; g_d = 2'b10; b_d = 2'b10; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_d_q         <= 1'b0;
      v_d_q         <= 1'b0;
      x_cnt_q       <= 10'd0;
      bar_sub_q     <= 7'd0;
      bar_idx_q     <= 3'd0;
      y_cnt_q       <= 9'd0;
      active_mode_q <= 2'd0;
      bx_q          <= 10'd0;
      by_q          <= 9'd0;
      dx_q          <= 1'b1;
      dy_q          <= 1'b1;
      r_q           <= 2'b00;
      g_q           <= 2'b00;
      b_q           <= 2'b00;
      x_pos_q       <= 10'd0;
      y_pos_q       <= 9'd0;
    end else begin
      h_d_q         <= h_d_d;
      v_d_q         <= v_d_d;
      x_cnt_q       <= x_cnt_d;
      bar_sub_q     <= bar_sub_d;
      bar_idx_q     <= bar_idx_d;
      y_cnt_q       <= y_cnt_d;
      active_mode_q <= active_mode_d;
      bx_q          <= bx_d;
      by_q          <= by_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      x_pos_q       <= x_pos_d;
      y_pos_q       <= y_pos_d;
    end
  end

  assign vga.R_out = r_q;
  assign vga.G_out = g_q;
  assign vga.B_out = b_q;
  assign vga.x_pos = x_pos_q;
  assign vga.y_pos = y_pos_q;
endmodule
